// File: rtl/filter_mode_ctrl_pkg.sv
// Shared types, field positions and helpers for the filter-mode controller.
// Decodes the debounced switch word into a mode and MAP sub-mode.
package filter_mode_pkg;

  localparam int unsigned SW_W  = 10;
  localparam int unsigned IDX_W = 5;

  localparam logic [IDX_W-1:0] MAP_MAX = 5'd26;

  localparam int unsigned MODE_HI  = 9;
  localparam int unsigned MODE_LO  = 8;
  localparam int unsigned AUTO_BIT = 7;
  localparam int unsigned STEP_BIT = 6;

  typedef enum logic [1:0] {
    MODE_BYPASS,
    MODE_SWAP,
    MODE_MAP
  } mode_e;

  typedef enum logic [1:0] {
    SUB_MANUAL,
    SUB_STEP,
    SUB_AUTO
  } map_sub_e;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH,
    ST_ARMED,
    ST_COMMIT
  } commit_st_e;

  function automatic mode_e decode_mode(input logic [1:0] bits);
    case (bits)
      2'b10:   return MODE_SWAP;
      2'b01:   return MODE_MAP;
      default: return MODE_BYPASS;
    endcase
  endfunction

  // AUTO outranks STEP when both switches are up.
  function automatic map_sub_e decode_sub(input logic auto_b, input logic step_b);
    if (auto_b) begin
      return SUB_AUTO;
    end else if (step_b) begin
      return SUB_STEP;
    end
    return SUB_MANUAL;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i >= MAP_MAX) ? '0 : i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/filter_mode_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a whole-word debouncer: the word is accepted
// once the synchronised value has matched the candidate for N cycles.
module sw_debounce #(
  parameter int              W       = 1,
  parameter int              N       = 4,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [W-1:0]  sync1_q, sync1_d;
  logic [W-1:0]  sync2_q, sync2_d;
  logic [W-1:0]  cand_q,  cand_d;
  logic [W-1:0]  db_q,    db_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    // Any bit moving restarts the window; the counter parks at its last value.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d = cand_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      cand_q  <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/filter_mode_ctrl.sv
// Builds the filter-selection word from debounced switches and the step key and
// commits it on the synchronised VS falling edge so the filter never changes mid-frame.
module filter_mode_ctrl
  import filter_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int AUTO_FRAMES  = 60
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [SW_W-1:0]  iSW,
  input  logic             iKEY_N,
  input  logic             iVS_N,
  output logic [SW_W-1:0]  oSW,
  output logic [IDX_W-1:0] oIDX,
  output logic             oCHANGED
);

  localparam int            FW         = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

  logic [SW_W-1:0]  db_sw;
  logic             db_key;
  logic             db_sw_unused;

  logic             vs_meta_q,  vs_meta_d;
  logic             vs_sync_q,  vs_sync_d;
  logic             vs_prev_q,  vs_prev_d;
  logic             key_prev_q, key_prev_d;
  logic [FW-1:0]    fcnt_q,     fcnt_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  commit_st_e       state_q,    state_d;
  logic [SW_W-1:0]  osw_q,      osw_d;
  logic [IDX_W-1:0] oidx_q,     oidx_d;
  logic             ochg_q,     ochg_d;

  logic             key_press;
  logic             vs_fall;
  logic             in_auto;
  logic             frame_wrap;
  mode_e            mode;
  map_sub_e         sub;
  logic [IDX_W-1:0] idx_next;
  logic [SW_W-1:0]  pending;

  sw_debounce #(
    .W       (SW_W),
    .N       (DEBOUNCE_CYC),
    .RST_VAL ('0)
  ) u_sw_db (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .din   (iSW),
    .dout  (db_sw)
  );

  sw_debounce #(
    .W       (1),
    .N       (DEBOUNCE_CYC),
    .RST_VAL (1'b1)
  ) u_key_db (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .din   (iKEY_N),
    .dout  (db_key)
  );

  assign db_sw_unused = db_sw[5];

  always_comb begin
    vs_meta_d  = iVS_N;
    vs_sync_d  = vs_meta_q;
    vs_prev_d  = vs_sync_q;
    key_prev_d = db_key;

    key_press  = key_prev_q & ~db_key;
    vs_fall    = vs_prev_q & ~vs_sync_q;
    mode       = decode_mode(db_sw[MODE_HI:MODE_LO]);
    sub        = decode_sub(db_sw[AUTO_BIT], db_sw[STEP_BIT]);
    in_auto    = (mode == MODE_MAP) && (sub == SUB_AUTO);
    frame_wrap = in_auto && vs_fall && (fcnt_q == FRAME_LAST);

    fcnt_d = '0;
    if (in_auto) begin
      if (frame_wrap) begin
        fcnt_d = '0;
      end else if (vs_fall) begin
        fcnt_d = fcnt_q + FW'(1);
      end else begin
        fcnt_d = fcnt_q;
      end
    end

    // A key press landing on a frame wrap still advances only once.
    idx_next = idx_q;
    if (mode == MODE_MAP) begin
      case (sub)
        SUB_MANUAL: if (db_sw[IDX_W-1:0] <= MAP_MAX) idx_next = db_sw[IDX_W-1:0];
        SUB_STEP:   if (key_press) idx_next = idx_inc(idx_q);
        SUB_AUTO:   if (key_press || frame_wrap) idx_next = idx_inc(idx_q);
        default:    idx_next = idx_q;
      endcase
    end
    idx_d = idx_next;

    case (mode)
      MODE_SWAP: pending = {2'b10, 5'b00000, db_sw[2:0]};
      MODE_MAP:  pending = {2'b01, 3'b000, idx_next};
      default:   pending = {db_sw[MODE_HI:MODE_LO], 8'h00};
    endcase

    // Outputs load on the ARMED->COMMIT edge so they are visible during COMMIT,
    // three cycles after the raw VS fall.
    state_d = state_q;
    osw_d   = osw_q;
    oidx_d  = oidx_q;
    ochg_d  = 1'b0;
    case (state_q)
      ST_WAIT_HIGH: if (vs_sync_q) state_d = ST_ARMED;
      ST_ARMED: begin
        if (vs_fall) begin
          state_d = ST_COMMIT;
          osw_d   = pending;
          oidx_d  = idx_next;
          ochg_d  = (pending != osw_q);
        end
      end
      ST_COMMIT:    state_d = ST_WAIT_HIGH;
      default:      state_d = ST_WAIT_HIGH;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      key_prev_q <= 1'b1;
      fcnt_q     <= '0;
      idx_q      <= '0;
      state_q    <= ST_WAIT_HIGH;
      osw_q      <= '0;
      oidx_q     <= '0;
      ochg_q     <= 1'b0;
    end else begin
      vs_meta_q  <= vs_meta_d;
      vs_sync_q  <= vs_sync_d;
      vs_prev_q  <= vs_prev_d;
      key_prev_q <= key_prev_d;
      fcnt_q     <= fcnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      osw_q      <= osw_d;
      oidx_q     <= oidx_d;
      ochg_q     <= ochg_d;
    end
  end

  assign oSW      = osw_q;
  assign oIDX     = oidx_q;
  assign oCHANGED = ochg_q;

endmodule
